// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - byte-addressable data memory with combinational loads, lane stores and sticky error capture
module data_mem_responder #(
  parameter int size        = 32,
  parameter int DEPTH_WORDS = 1024
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [size-1:0] RAM_Addr_i,
  input  logic [size-1:0] RAM_DATA_i,
  input  logic [2:0]      RAM_DATA_control,
  input  logic            RAM_rw,
  input  logic            err_clr,
  output logic [size-1:0] MEM_result_o,
  output logic            err,
  output logic [size-1:0] err_addr,
  output logic [1:0]      err_code,
  output logic [15:0]     store_cnt
);

  localparam int AW = $clog2(DEPTH_WORDS);

  logic [31:0]   mem [DEPTH_WORDS];
  logic [AW-1:0] idx;
  logic [1:0]    lane;
  logic [1:0]    sz;

  assign idx  = RAM_Addr_i[AW+1:2];
  assign lane = RAM_Addr_i[1:0];
  assign sz   = RAM_DATA_control[1:0];

  logic       illegal;
  logic       out_of_range;
  logic       misaligned;
  logic [1:0] acc_code;
  logic       acc_err;
  logic       commit;

  // Classify the current access; illegal control outranks out-of-range, which outranks misalignment
  always_comb begin
    illegal      = 1'b0;
    if (RAM_rw) begin
      illegal = RAM_DATA_control[2] || (sz == 2'b11);
    end else begin
      illegal = !(RAM_DATA_control inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    end
    out_of_range = |RAM_Addr_i[size-1:AW+2];
    misaligned   = ((sz == 2'b01) && lane[0]) || ((sz == 2'b10) && (lane != 2'b00));
    if (illegal)           acc_code = 2'b11;
    else if (out_of_range) acc_code = 2'b10;
    else if (misaligned)   acc_code = 2'b01;
    else                   acc_code = 2'b00;
    acc_err = (acc_code != 2'b00);
    commit  = reset && RAM_rw && !acc_err;
  end

  logic [31:0] rdata;
  logic [7:0]  b8;
  logic [15:0] h16;

  // Combinational load path: select lane, then sign- or zero-extend; errors and reset force zero
  always_comb begin
    rdata = mem[idx];
    case (lane)
      2'd0:    b8 = rdata[7:0];
      2'd1:    b8 = rdata[15:8];
      2'd2:    b8 = rdata[23:16];
      default: b8 = rdata[31:24];
    endcase
    h16 = lane[1] ? rdata[31:16] : rdata[15:0];
    case (RAM_DATA_control)
      3'b000:  MEM_result_o = {{(size-8){b8[7]}}, b8};
      3'b100:  MEM_result_o = {{(size-8){1'b0}}, b8};
      3'b001:  MEM_result_o = {{(size-16){h16[15]}}, h16};
      3'b101:  MEM_result_o = {{(size-16){1'b0}}, h16};
      3'b010:  MEM_result_o = size'(rdata);
      default: MEM_result_o = '0;
    endcase
    if (!reset || acc_err) MEM_result_o = '0;
  end

  logic [3:0]  be;
  logic [31:0] wdata;

  // Store byte enables and lane-replicated write data
  always_comb begin
    case (sz)
      2'b00: begin
        be    = 4'b0001 << lane;
        wdata = {4{RAM_DATA_i[7:0]}};
      end
      2'b01: begin
        be    = lane[1] ? 4'b1100 : 4'b0011;
        wdata = {2{RAM_DATA_i[15:0]}};
      end
      default: begin
        be    = 4'b1111;
        wdata = RAM_DATA_i[31:0];
      end
    endcase
  end

  // Array write: only enabled lanes of a legal store outside reset; contents survive reset
  always_ff @(posedge clk) begin
    if (commit) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  // Sticky error capture (new error beats clear) and committed-store counter
  always_ff @(posedge clk) begin
    if (!reset) begin
      err       <= 1'b0;
      err_addr  <= '0;
      err_code  <= 2'b00;
      store_cnt <= 16'h0000;
    end else begin
      if (acc_err && (!err || err_clr)) begin
        err      <= 1'b1;
        err_addr <= RAM_Addr_i;
        err_code <= acc_code;
      end else if (err_clr) begin
        err      <= 1'b0;
        err_addr <= '0;
        err_code <= 2'b00;
      end
      if (commit) store_cnt <= store_cnt + 16'h0001;
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// tb/tb_data_mem_responder.sv - scoreboard bench for data_mem_responder
module tb_data_mem_responder;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] RAM_Addr_i = '0;
  logic [31:0] RAM_DATA_i = '0;
  logic [2:0]  RAM_DATA_control = 3'b010;
  logic        RAM_rw = 1'b0;
  logic        err_clr = 1'b0;
  logic [31:0] MEM_result_o;
  logic        err;
  logic [31:0] err_addr;
  logic [1:0]  err_code;
  logic [15:0] store_cnt;

  data_mem_responder #(.size(32), .DEPTH_WORDS(1024)) dut (
    .clk(clk), .reset(reset), .RAM_Addr_i(RAM_Addr_i), .RAM_DATA_i(RAM_DATA_i),
    .RAM_DATA_control(RAM_DATA_control), .RAM_rw(RAM_rw), .err_clr(err_clr),
    .MEM_result_o(MEM_result_o), .err(err), .err_addr(err_addr),
    .err_code(err_code), .store_cnt(store_cnt)
  );

  always #5 clk = ~clk;

  localparam int K_RES = 0, K_ERR = 1, K_ADDR = 2, K_CODE = 3, K_CNT = 4;

  typedef struct {
    string       name;
    int          kind;
    logic [31:0] exp;
  } chk_t;

  chk_t sb[$];
  int   n_vec  = 0;
  int   n_fail = 0;

  task automatic drive(input logic [31:0] a, input logic [31:0] d, input logic [2:0] c,
                       input logic rw, input logic clr, input logic rst);
    @(posedge clk);
    #1;
    RAM_Addr_i       = a;
    RAM_DATA_i       = d;
    RAM_DATA_control = c;
    RAM_rw           = rw;
    err_clr          = clr;
    reset            = rst;
  endtask

  task automatic expect_val(input string name, input int kind, input logic [31:0] exp);
    chk_t item;
    item.name = name;
    item.kind = kind;
    item.exp  = exp;
    sb.push_back(item);
  endtask

  // Monitor: every cycle the outputs are settled, pop and compare all pending expectations
  initial begin
    forever begin
      @(negedge clk);
      while (sb.size() > 0) begin
        chk_t        it;
        logic [31:0] act;
        it = sb.pop_front();
        case (it.kind)
          K_RES:   act = MEM_result_o;
          K_ERR:   act = {31'b0, err};
          K_ADDR:  act = err_addr;
          K_CODE:  act = {30'b0, err_code};
          default: act = {16'b0, store_cnt};
        endcase
        n_vec++;
        if (act !== it.exp) begin
          n_fail++;
          $display("FAIL %s: got 0x%08h, expected 0x%08h", it.name, act, it.exp);
        end
      end
    end
  end

  initial begin
    // Reset state
    drive(32'h0, 32'h0, 3'b010, 1'b0, 1'b0, 1'b0);
    drive(32'h0, 32'h0, 3'b010, 1'b0, 1'b0, 1'b0);
    expect_val("rst_result", K_RES, 32'h0);
    expect_val("rst_err", K_ERR, 32'h0);
    expect_val("rst_err_addr", K_ADDR, 32'h0);
    expect_val("rst_err_code", K_CODE, 32'h0);
    expect_val("rst_store_cnt", K_CNT, 32'h0);

    // Word store then loads of every flavour
    drive(32'h10, 32'hDEADBEEF, 3'b010, 1'b1, 1'b0, 1'b1);
    drive(32'h10, 32'h0, 3'b010, 1'b0, 1'b0, 1'b1);
    expect_val("lw_10", K_RES, 32'hDEADBEEF);
    expect_val("cnt_after_sw", K_CNT, 32'h1);
    expect_val("err_clean", K_ERR, 32'h0);
    drive(32'h13, 32'h0, 3'b000, 1'b0, 1'b0, 1'b1);
    expect_val("lb_13", K_RES, 32'hFFFFFFDE);
    drive(32'h13, 32'h0, 3'b100, 1'b0, 1'b0, 1'b1);
    expect_val("lbu_13", K_RES, 32'h000000DE);
    drive(32'h10, 32'h0, 3'b101, 1'b0, 1'b0, 1'b1);
    expect_val("lhu_10", K_RES, 32'h0000BEEF);

    // Sub-word stores touch only their lanes
    drive(32'h11, 32'h000000AA, 3'b000, 1'b1, 1'b0, 1'b1);
    drive(32'h10, 32'h0, 3'b010, 1'b0, 1'b0, 1'b1);
    expect_val("lw_after_sb", K_RES, 32'hDEADAAEF);
    drive(32'h12, 32'h00008001, 3'b001, 1'b1, 1'b0, 1'b1);
    drive(32'h10, 32'h0, 3'b010, 1'b0, 1'b0, 1'b1);
    expect_val("lw_after_sh", K_RES, 32'h8001AAEF);
    drive(32'h12, 32'h0, 3'b001, 1'b0, 1'b0, 1'b1);
    expect_val("lh_12", K_RES, 32'hFFFF8001);
    expect_val("cnt_3", K_CNT, 32'h3);

    // Misaligned store is blocked and captured; later errors do not overwrite
    drive(32'h14, 32'h11223344, 3'b010, 1'b1, 1'b0, 1'b1);
    drive(32'h16, 32'h55555555, 3'b010, 1'b1, 1'b0, 1'b1);
    drive(32'h14, 32'h0, 3'b010, 1'b0, 1'b0, 1'b1);
    expect_val("word14_unchanged", K_RES, 32'h11223344);
    expect_val("mis_err", K_ERR, 32'h1);
    expect_val("mis_code", K_CODE, 32'h1);
    expect_val("mis_addr", K_ADDR, 32'h16);
    expect_val("mis_cnt", K_CNT, 32'h4);
    drive(32'h4000, 32'h0, 3'b010, 1'b1, 1'b0, 1'b1);
    drive(32'h4000, 32'h0, 3'b010, 1'b0, 1'b0, 1'b1);
    expect_val("oor_load_zero", K_RES, 32'h0);
    expect_val("oor_addr_kept", K_ADDR, 32'h16);
    expect_val("oor_code_kept", K_CODE, 32'h1);
    drive(32'h10, 32'h0, 3'b011, 1'b0, 1'b0, 1'b1);
    expect_val("illegal_load_zero", K_RES, 32'h0);
    drive(32'h10, 32'h0, 3'b010, 1'b0, 1'b0, 1'b1);
    expect_val("lw_10_again", K_RES, 32'h8001AAEF);
    expect_val("cnt_still_4", K_CNT, 32'h4);

    // Error in the same cycle as clear wins; clear alone empties
    drive(32'h21, 32'h0, 3'b001, 1'b0, 1'b1, 1'b1);
    expect_val("mis_load_zero", K_RES, 32'h0);
    drive(32'h10, 32'h0, 3'b010, 1'b0, 1'b1, 1'b1);
    expect_val("clr_err_wins", K_ERR, 32'h1);
    expect_val("clr_err_addr", K_ADDR, 32'h21);
    expect_val("clr_err_code", K_CODE, 32'h1);
    drive(32'h10, 32'h0, 3'b010, 1'b0, 1'b0, 1'b1);
    expect_val("clr_err", K_ERR, 32'h0);
    expect_val("clr_addr", K_ADDR, 32'h0);
    expect_val("clr_code", K_CODE, 32'h0);

    // Priority: illegal over out-of-range, out-of-range over misaligned
    drive(32'h4001, 32'h0, 3'b100, 1'b1, 1'b0, 1'b1);
    drive(32'h10, 32'h0, 3'b010, 1'b0, 1'b1, 1'b1);
    expect_val("prio_illegal_code", K_CODE, 32'h3);
    expect_val("prio_illegal_addr", K_ADDR, 32'h4001);
    drive(32'h4002, 32'h0, 3'b010, 1'b1, 1'b0, 1'b1);
    drive(32'h10, 32'h0, 3'b010, 1'b0, 1'b1, 1'b1);
    expect_val("prio_oor_code", K_CODE, 32'h2);
    expect_val("prio_oor_addr", K_ADDR, 32'h4002);

    // Counter wrap
    for (int i = 0; i < 65531; i++) begin
      drive(32'h20, i, 3'b010, 1'b1, 1'b0, 1'b1);
    end
    drive(32'h20, 32'h0, 3'b010, 1'b0, 1'b0, 1'b1);
    expect_val("cnt_ffff", K_CNT, 32'hFFFF);
    expect_val("err_after_clear", K_ERR, 32'h0);
    drive(32'h20, 32'hCAFEF00D, 3'b010, 1'b1, 1'b0, 1'b1);
    drive(32'h20, 32'h0, 3'b010, 1'b0, 1'b0, 1'b1);
    expect_val("cnt_wrap", K_CNT, 32'h0);
    expect_val("lw_20", K_RES, 32'hCAFEF00D);

    // Reset mid-sequence suppresses the store but keeps contents
    drive(32'h0, 32'hA5A5A5A5, 3'b010, 1'b1, 1'b0, 1'b1);
    drive(32'h0, 32'h12345678, 3'b010, 1'b1, 1'b0, 1'b0);
    expect_val("result_in_reset", K_RES, 32'h0);
    drive(32'h0, 32'h0, 3'b010, 1'b0, 1'b0, 1'b1);
    expect_val("word0_kept", K_RES, 32'hA5A5A5A5);
    expect_val("cnt_after_reset", K_CNT, 32'h0);
    expect_val("err_after_reset", K_ERR, 32'h0);

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
    if (sb.size() > 0) begin
      n_vec++;
      n_fail++;
      $display("FAIL drain: %0d checks pending, expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
